// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: access-size encodings, issue states
// and the access legality check.
package dmem_pkg;

   localparam logic [2:0] ST_B  = 3'b000;
   localparam logic [2:0] ST_H  = 3'b001;
   localparam logic [2:0] ST_W  = 3'b010;

   localparam logic [2:0] LD_B  = 3'b000;
   localparam logic [2:0] LD_H  = 3'b001;
   localparam logic [2:0] LD_W  = 3'b010;
   localparam logic [2:0] LD_BU = 3'b100;
   localparam logic [2:0] LD_HU = 3'b101;

   typedef enum logic [1:0] {
      ISS_NONE = 2'd0,
      ISS_CORE = 2'd1,
      ISS_HOST = 2'd2
   } iss_state_e;

   // True when the access is misaligned for its size or uses an undefined size code.
   function automatic logic misaligned(input logic       we,
                                       input logic [2:0] store_sel,
                                       input logic [2:0] load_sel,
                                       input logic [1:0] addr_lo);
      logic bad;
      bad = 1'b0;
      if (we) begin
         case (store_sel)
            ST_B:    bad = 1'b0;
            ST_H:    bad = addr_lo[0];
            ST_W:    bad = |addr_lo;
            default: bad = 1'b1;
         endcase
      end else begin
         case (load_sel)
            LD_B, LD_BU: bad = 1'b0;
            LD_H, LD_HU: bad = addr_lo[0];
            LD_W:        bad = |addr_lo;
            default:     bad = 1'b1;
         endcase
      end
      return bad;
   endfunction

endpackage

// File: rtl/dmem_arbiter_load_extract.sv
// Load lane extraction: selects the byte/half addressed by offset and sign/zero extends it.
module load_extract
   import dmem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [2:0]  load_sel,
   output logic [31:0] result
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = word[{offset, 3'b000} +: 8];
      lane_h = offset[1] ? word[31:16] : word[15:0];
      case (load_sel)
         LD_B:    result = {{24{lane_b[7]}}, lane_b};
         LD_BU:   result = {24'h000000, lane_b};
         LD_H:    result = {{16{lane_h[15]}}, lane_h};
         LD_HU:   result = {16'h0000, lane_h};
         default: result = word;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port dmem between the MEM stage and the host/loader port.
// Core load lane extraction is built only when DMEM_ARB_LOAD_EXT_EN is defined.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned AW           = 11
) (
   input  logic          clk,
   input  logic          rst,

   input  logic          core_req,
   input  logic          core_we,
   input  logic [2:0]    core_store_sel,
   input  logic [2:0]    core_load_sel,
   input  logic [AW-1:0] core_addr,
   input  logic [31:0]   core_wdata,
   output logic          core_stall,
   output logic          core_rvalid,
   output logic [31:0]   core_rdata,
   output logic          core_err,

   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [31:0]   host_wdata,
   output logic          host_ready,
   output logic          host_rvalid,
   output logic [31:0]   host_rdata,

   output logic          write_enable_dmem,
   output logic [2:0]    store_sel_M,
   output logic [AW-1:0] mem_WA,
   output logic [31:0]   mem_WD,
   input  logic [31:0]   mem_RD
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic          host_grant;
   logic          core_grant;
   logic          core_legal;
   logic [3:0]    starve_cnt;

   iss_state_e    iss_state;
   logic          iss_we;
   logic          iss_err;
   logic [2:0]    iss_store_sel;
   logic [AW-1:0] iss_addr;
   logic [31:0]   iss_wdata;
   logic [31:0]   core_word;

   // Grants are held off while reset is asserted so every output reads 0 during reset.
   always_comb begin
      host_grant = !rst && host_req && (!core_req || (starve_cnt == LIMIT));
      core_grant = !rst && core_req && !host_grant;
      core_legal = !misaligned(core_we, core_store_sel, core_load_sel, core_addr[1:0]);
   end

   assign core_stall = core_req & host_grant;
   assign host_ready = host_grant;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= 4'd0;
      end else if (!host_req || host_grant) begin
         starve_cnt <= 4'd0;
      end else if (core_grant && (starve_cnt != LIMIT)) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

`ifdef DMEM_ARB_LOAD_EXT_EN
   logic [2:0] iss_load_sel;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         iss_load_sel <= 3'b000;
      end else if (host_grant) begin
         iss_load_sel <= LD_W;
      end else if (core_grant) begin
         iss_load_sel <= core_load_sel;
      end
   end

   load_extract u_load_extract (
      .word     (mem_RD),
      .offset   (iss_addr[1:0]),
      .load_sel (iss_load_sel),
      .result   (core_word)
   );
`else
   assign core_word = mem_RD;
`endif

   // Issue stage: one accepted request lives here for exactly one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         iss_state     <= ISS_NONE;
         iss_we        <= 1'b0;
         iss_err       <= 1'b0;
         iss_store_sel <= 3'b000;
         iss_addr      <= '0;
         iss_wdata     <= 32'h0;
      end else begin
         iss_err <= core_grant && !core_legal;
         if (host_grant) begin
            iss_state     <= ISS_HOST;
            iss_we        <= host_we;
            iss_store_sel <= ST_W;
            iss_addr      <= {host_addr[AW-1:2], 2'b00};
            iss_wdata     <= host_wdata;
         end else if (core_grant && core_legal) begin
            iss_state     <= ISS_CORE;
            iss_we        <= core_we;
            iss_store_sel <= core_store_sel;
            iss_addr      <= core_addr;
            iss_wdata     <= core_wdata;
         end else begin
            iss_state <= ISS_NONE;
            iss_we    <= 1'b0;
         end
      end
   end

   // dmem drive comes straight from the issue register, so reset drops it asynchronously.
   always_comb begin
      write_enable_dmem = 1'b0;
      store_sel_M       = 3'b000;
      mem_WA            = '0;
      mem_WD            = 32'h0;
      if (iss_state != ISS_NONE) begin
         write_enable_dmem = iss_we;
         store_sel_M       = iss_store_sel;
         mem_WA            = iss_addr;
         mem_WD            = iss_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         core_rvalid <= 1'b0;
         core_rdata  <= 32'h0;
         core_err    <= 1'b0;
         host_rvalid <= 1'b0;
         host_rdata  <= 32'h0;
      end else begin
         core_rvalid <= (iss_state == ISS_CORE) && !iss_we;
         host_rvalid <= (iss_state == ISS_HOST) && !iss_we;
         core_err    <= iss_err;
         if ((iss_state == ISS_CORE) && !iss_we) begin
            core_rdata <= core_word;
         end
         if ((iss_state == ISS_HOST) && !iss_we) begin
            host_rdata <= mem_RD;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural byte-lane dmem model.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        core_req, core_we;
   logic [2:0]  core_store_sel, core_load_sel;
   logic [10:0] core_addr;
   logic [31:0] core_wdata;
   logic        core_stall, core_rvalid, core_err;
   logic [31:0] core_rdata;
   logic        host_req, host_we;
   logic [10:0] host_addr;
   logic [31:0] host_wdata;
   logic        host_ready, host_rvalid;
   logic [31:0] host_rdata;
   logic        write_enable_dmem;
   logic [2:0]  store_sel_M;
   logic [10:0] mem_WA;
   logic [31:0] mem_WD, mem_RD;

   int checks = 0;
   int errors = 0;
   logic [31:0] last_core = 32'h0;
   logic [31:0] last_host = 32'h0;
   logic        mem_init;
   logic [31:0] mem [0:511];

   always #5 clk = ~clk;

   dmem_arbiter #(.STARVE_LIMIT(4), .AW(11)) dut (
      .clk(clk), .rst(rst),
      .core_req(core_req), .core_we(core_we), .core_store_sel(core_store_sel),
      .core_load_sel(core_load_sel), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
      .core_err(core_err),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_ready(host_ready), .host_rvalid(host_rvalid),
      .host_rdata(host_rdata),
      .write_enable_dmem(write_enable_dmem), .store_sel_M(store_sel_M), .mem_WA(mem_WA),
      .mem_WD(mem_WD), .mem_RD(mem_RD)
   );

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [2:0] sel, input logic [1:0] lo);
      logic [31:0] r;
      r = old;
      case (sel)
         3'b000: case (lo)
                    2'd0: r[7:0]   = wd[7:0];
                    2'd1: r[15:8]  = wd[7:0];
                    2'd2: r[23:16] = wd[7:0];
                    default: r[31:24] = wd[7:0];
                 endcase
         3'b001: if (lo[1]) r[31:16] = wd[15:0]; else r[15:0] = wd[15:0];
         default: r = wd;
      endcase
      return r;
   endfunction

   assign mem_RD = mem[mem_WA[10:2]];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
      end else if (write_enable_dmem) begin
         mem[mem_WA[10:2]] <= merge(mem[mem_WA[10:2]], mem_WD, store_sel_M, mem_WA[1:0]);
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, got, exp);
      end
   endtask

   typedef struct {
      logic        host;
      logic        we;
      logic [2:0]  sel;
      logic [10:0] addr;
      logic [31:0] wdata;
      logic        exp_rv;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs [18];

   task automatic run_vec(input vec_t v, input int idx);
      logic [10:0] exp_wa;
      @(negedge clk);
      if (v.host) begin
         host_req = 1'b1; host_we = v.we; host_addr = v.addr; host_wdata = v.wdata;
      end else begin
         core_req = 1'b1; core_we = v.we; core_store_sel = v.sel; core_load_sel = v.sel;
         core_addr = v.addr; core_wdata = v.wdata;
      end
      #1;
      if (v.host) check($sformatf("v%0d host_ready", idx), 32'(host_ready), 32'd1);
      else        check($sformatf("v%0d core_stall", idx), 32'(core_stall), 32'd0);
      @(posedge clk); #1;
      core_req = 1'b0; host_req = 1'b0;
      exp_wa = v.host ? {v.addr[10:2], 2'b00} : v.addr;
      check($sformatf("v%0d mem_WA", idx), 32'(mem_WA), v.exp_err ? 32'd0 : 32'(exp_wa));
      check($sformatf("v%0d we_dmem", idx), 32'(write_enable_dmem), 32'(v.we && !v.exp_err));
      @(posedge clk); #1;
      if (v.host) begin
         if (v.exp_rv) last_host = v.exp_rdata;
         check($sformatf("v%0d host_rvalid", idx), 32'(host_rvalid), 32'(v.exp_rv));
         check($sformatf("v%0d host_rdata", idx), host_rdata, last_host);
         check($sformatf("v%0d core_rvalid", idx), 32'(core_rvalid), 32'd0);
      end else begin
         if (v.exp_rv) last_core = v.exp_rdata;
         check($sformatf("v%0d core_rvalid", idx), 32'(core_rvalid), 32'(v.exp_rv));
         check($sformatf("v%0d core_rdata", idx), core_rdata, last_core);
         check($sformatf("v%0d core_err", idx), 32'(core_err), 32'(v.exp_err));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //        host we   sel     addr     wdata          rv    rdata          err
      vecs[0]  = '{0, 1, 3'b010, 11'h010, 32'hDEADBEEF, 0, 32'h0,        0};
`ifdef DMEM_ARB_LOAD_EXT_EN
      vecs[1]  = '{0, 0, 3'b100, 11'h013, 32'h0,        1, 32'h000000DE, 0};
      vecs[2]  = '{0, 0, 3'b000, 11'h012, 32'h0,        1, 32'hFFFFFFAD, 0};
      vecs[10] = '{0, 0, 3'b001, 11'h012, 32'h0,        1, 32'hFFFFDEAD, 0};
      vecs[11] = '{0, 0, 3'b101, 11'h010, 32'h0,        1, 32'h0000BEEF, 0};
`else
      vecs[1]  = '{0, 0, 3'b000, 11'h013, 32'h0,        1, 32'hDEADBEEF, 0};
      vecs[2]  = '{0, 0, 3'b000, 11'h012, 32'h0,        1, 32'hDEADBEEF, 0};
      vecs[10] = '{0, 0, 3'b001, 11'h012, 32'h0,        1, 32'hDEADBEEF, 0};
      vecs[11] = '{0, 0, 3'b101, 11'h010, 32'h0,        1, 32'hDEADBEEF, 0};
`endif
      vecs[3]  = '{1, 1, 3'b010, 11'h020, 32'hAAAAAAAA, 0, 32'h0,        0};
      vecs[4]  = '{0, 1, 3'b001, 11'h022, 32'h00001234, 0, 32'h0,        0};
      vecs[5]  = '{0, 0, 3'b010, 11'h020, 32'h0,        1, 32'h1234AAAA, 0};
      vecs[6]  = '{0, 1, 3'b001, 11'h021, 32'h00005678, 0, 32'h0,        1};
      vecs[7]  = '{0, 0, 3'b010, 11'h020, 32'h0,        1, 32'h1234AAAA, 0};
      vecs[8]  = '{1, 1, 3'b010, 11'h043, 32'hCAFEF00D, 0, 32'h0,        0};
      vecs[9]  = '{1, 0, 3'b010, 11'h040, 32'h0,        1, 32'hCAFEF00D, 0};
      vecs[12] = '{0, 0, 3'b010, 11'h011, 32'h0,        0, 32'h0,        1};
      vecs[13] = '{0, 0, 3'b011, 11'h010, 32'h0,        0, 32'h0,        1};
      vecs[14] = '{0, 1, 3'b011, 11'h010, 32'h0,        0, 32'h0,        1};
      vecs[15] = '{0, 1, 3'b000, 11'h041, 32'h00000055, 0, 32'h0,        0};
      vecs[16] = '{0, 0, 3'b010, 11'h040, 32'h0,        1, 32'hCAFE550D, 0};
      vecs[17] = '{1, 0, 3'b010, 11'h043, 32'h0,        1, 32'hCAFE550D, 0};

      rst = 1'b1; mem_init = 1'b1;
      core_req = 0; core_we = 0; core_store_sel = 0; core_load_sel = 0;
      core_addr = 0; core_wdata = 0;
      host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
      @(posedge clk); @(posedge clk); #1;
      mem_init = 1'b0;
      check("reset outputs",
            {16'h0, 5'h0, core_stall, core_rvalid, core_err, host_ready, host_rvalid,
             write_enable_dmem, store_sel_M, 1'b0}, 32'h0);
      check("reset mem_WA", 32'(mem_WA), 32'h0);
      check("reset core_rdata", core_rdata, 32'h0);
      check("reset host_rdata", host_rdata, 32'h0);
      @(negedge clk); rst = 1'b0;

      for (int i = 0; i < 18; i++) run_vec(vecs[i], i);

      // Starvation: both ports request every cycle; host is forced in every 5th cycle.
      @(negedge clk);
      core_req = 1; core_we = 0; core_load_sel = 3'b010; core_store_sel = 3'b010;
      core_addr = 11'h020;
      host_req = 1; host_we = 0; host_addr = 11'h040;
      for (int i = 0; i < 15; i++) begin
         #1;
         check($sformatf("starve c%0d host_ready", i), 32'(host_ready), 32'((i % 5) == 4));
         check($sformatf("starve c%0d core_stall", i), 32'(core_stall), 32'((i % 5) == 4));
         @(negedge clk);
      end
      core_req = 0; host_req = 0;
      @(negedge clk); @(negedge clk);
      last_core = 32'h1234AAAA;
      last_host = 32'hCAFE550D;
      check("starve core_rdata", core_rdata, last_core);
      check("starve host_rdata", host_rdata, last_host);

      // Store immediately followed by a load of the same address sees the new word.
      core_req = 1; core_we = 1; core_store_sel = 3'b010; core_addr = 11'h080;
      core_wdata = 32'h11223344;
      @(negedge clk);
      core_we = 0; core_load_sel = 3'b010;
      @(negedge clk);
      core_req = 0;
      @(posedge clk); #1;
      check("b2b core_rvalid", 32'(core_rvalid), 32'd1);
      check("b2b core_rdata", core_rdata, 32'h11223344);

      // Reset during an issued store: dmem write enable drops at once and the store is lost.
      @(negedge clk);
      core_req = 1; core_we = 1; core_store_sel = 3'b010; core_addr = 11'h080;
      core_wdata = 32'h99999999;
      @(posedge clk); #1;
      core_req = 0;
      check("rst pre we_dmem", 32'(write_enable_dmem), 32'd1);
      #1 rst = 1'b1;
      #1;
      check("rst async we_dmem", 32'(write_enable_dmem), 32'd0);
      check("rst async mem_WA", 32'(mem_WA), 32'd0);
      check("rst async mem_WD", mem_WD, 32'd0);
      check("rst async core_rdata", core_rdata, 32'd0);
      check("rst async host_rdata", host_rdata, 32'd0);
      @(posedge clk); #1;
      check("rst mem kept", mem[11'h080 >> 2], 32'h11223344);
      @(negedge clk); rst = 1'b0;
      last_core = 32'h0;
      last_host = 32'h0;
      run_vec('{0, 0, 3'b010, 11'h080, 32'h0, 1, 32'h11223344, 0}, 99);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
